// File: rtl/trap_ctrl.sv
// Machine-mode trap controller: arbitrates exceptions and MRET, sequences
// flush/commit/redirect and owns mstatus, mtvec, mepc, mcause and mtval.
module trap_ctrl #(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_MTVEC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_exc_valid,
  input  logic [3:0]      if_exc_cause,
  input  logic [XLEN-1:0] if_exc_pc,
  input  logic [XLEN-1:0] if_exc_tval,
  input  logic            ex_exc_valid,
  input  logic [3:0]      ex_exc_cause,
  input  logic [XLEN-1:0] ex_exc_pc,
  input  logic [XLEN-1:0] ex_exc_tval,
  input  logic            ex_mret,
  output logic            exc_ready,
  output logic            flush,
  input  logic            drained,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  input  logic            redirect_ready,
  input  logic            csr_valid,
  input  logic [11:0]     csr_addr,
  input  logic            csr_we,
  input  logic [XLEN-1:0] csr_wdata,
  output logic [XLEN-1:0] csr_rdata,
  output logic            csr_hit,
  output logic            csr_ready
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_FLUSH  = 2'd1;
  localparam logic [1:0] S_COMMIT = 2'd2;
  localparam logic [1:0] S_REDIR  = 2'd3;

  localparam logic [11:0] A_MSTATUS = 12'h300;
  localparam logic [11:0] A_MTVEC   = 12'h305;
  localparam logic [11:0] A_MEPC    = 12'h341;
  localparam logic [11:0] A_MCAUSE  = 12'h342;
  localparam logic [11:0] A_MTVAL   = 12'h343;

  localparam logic [XLEN-1:0] ALIGN = ~XLEN'(3);

  logic [1:0]      r_state;
  logic [1:0]      w_next;
  logic            r_mret;
  logic [3:0]      r_cause;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_tval;
  logic [XLEN-1:0] r_mtvec;
  logic [XLEN-1:0] r_mepc;
  logic [XLEN-1:0] r_mcause;
  logic [XLEN-1:0] r_mtval;
  logic            r_mie;
  logic            r_mpie;

  logic            w_idle;
  logic            w_take_ex;
  logic            w_take_mret;
  logic            w_take_if;
  logic            w_accept;
  logic            w_csr_wr;
  logic            w_hit;
  logic [XLEN-1:0] w_rdata;

  // Exec holds the older instruction, so it wins over MRET and ifetch.
  assign w_idle      = rst && (r_state == S_IDLE);
  assign w_take_ex   = w_idle && ex_exc_valid;
  assign w_take_mret = w_idle && !ex_exc_valid && ex_mret;
  assign w_take_if   = w_idle && !ex_exc_valid && !ex_mret && if_exc_valid;
  assign w_accept    = w_take_ex || w_take_mret || w_take_if;

  assign exc_ready = w_idle;
  assign flush     = w_accept;
  assign csr_ready = w_idle && csr_valid && !w_accept;
  assign w_csr_wr  = csr_ready && csr_we && w_hit;

  assign redirect_valid = rst && (r_state == S_REDIR);
  assign redirect_pc    = !redirect_valid ? '0 :
                          r_mret ? r_mepc : (r_mtvec & ALIGN);

  always_comb begin
    w_hit   = 1'b1;
    w_rdata = '0;
    case (csr_addr)
      A_MSTATUS: begin
        w_rdata[3] = r_mie;
        w_rdata[7] = r_mpie;
      end
      A_MTVEC:  w_rdata = r_mtvec;
      A_MEPC:   w_rdata = r_mepc;
      A_MCAUSE: w_rdata = r_mcause;
      A_MTVAL:  w_rdata = r_mtval;
      default:  w_hit   = 1'b0;
    endcase
  end

  assign csr_hit   = rst && w_hit;
  assign csr_rdata = csr_hit ? w_rdata : '0;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_next = S_FLUSH;
      S_FLUSH:  if (drained) w_next = S_COMMIT;
      S_COMMIT: w_next = S_REDIR;
      S_REDIR:  if (redirect_ready) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_mret  <= 1'b0;
      r_cause <= '0;
      r_pc    <= '0;
      r_tval  <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_mret  <= w_take_mret;
        r_cause <= w_take_ex ? ex_exc_cause : if_exc_cause;
        r_pc    <= w_take_ex ? ex_exc_pc : if_exc_pc;
        r_tval  <= w_take_ex ? ex_exc_tval : if_exc_tval;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mtvec  <= RESET_MTVEC;
      r_mepc   <= '0;
      r_mcause <= '0;
      r_mtval  <= '0;
      r_mie    <= 1'b0;
      r_mpie   <= 1'b0;
    end else if (r_state == S_COMMIT) begin
      if (r_mret) begin
        r_mie  <= r_mpie;
        r_mpie <= 1'b1;
      end else begin
        r_mepc   <= r_pc & ALIGN;
        r_mcause <= {{(XLEN-4){1'b0}}, r_cause};
        r_mtval  <= r_tval;
        r_mpie   <= r_mie;
        r_mie    <= 1'b0;
      end
    end else if (w_csr_wr) begin
      case (csr_addr)
        A_MSTATUS: begin
          r_mie  <= csr_wdata[3];
          r_mpie <= csr_wdata[7];
        end
        A_MTVEC:  r_mtvec  <= csr_wdata;
        A_MEPC:   r_mepc   <= csr_wdata & ALIGN;
        A_MCAUSE: r_mcause <= csr_wdata;
        A_MTVAL:  r_mtval  <= csr_wdata;
        default:  ;
      endcase
    end
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: trap/MRET sequencing, arbitration,
// CSR access rules, stalls and mid-sequence reset.
module tb_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_exc_valid;
  logic [3:0]  if_exc_cause;
  logic [31:0] if_exc_pc;
  logic [31:0] if_exc_tval;
  logic        ex_exc_valid;
  logic [3:0]  ex_exc_cause;
  logic [31:0] ex_exc_pc;
  logic [31:0] ex_exc_tval;
  logic        ex_mret;
  logic        exc_ready;
  logic        flush;
  logic        drained;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        redirect_ready;
  logic        csr_valid;
  logic [11:0] csr_addr;
  logic        csr_we;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        csr_hit;
  logic        csr_ready;

  int errors = 0;
  int checks = 0;

  trap_ctrl #(.XLEN(32), .RESET_MTVEC(32'h0)) dut (
    .clk(clk), .rst(rst),
    .if_exc_valid(if_exc_valid), .if_exc_cause(if_exc_cause),
    .if_exc_pc(if_exc_pc), .if_exc_tval(if_exc_tval),
    .ex_exc_valid(ex_exc_valid), .ex_exc_cause(ex_exc_cause),
    .ex_exc_pc(ex_exc_pc), .ex_exc_tval(ex_exc_tval),
    .ex_mret(ex_mret), .exc_ready(exc_ready), .flush(flush),
    .drained(drained), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .redirect_ready(redirect_ready),
    .csr_valid(csr_valid), .csr_addr(csr_addr), .csr_we(csr_we),
    .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
    .csr_hit(csr_hit), .csr_ready(csr_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic csr_wr(input logic [11:0] a, input logic [31:0] d);
    csr_valid = 1'b1;
    csr_we    = 1'b1;
    csr_addr  = a;
    csr_wdata = d;
    tick();
    csr_valid = 1'b0;
    csr_we    = 1'b0;
  endtask

  task automatic csr_rd(input string tag, input logic [11:0] a,
                        input logic [31:0] exp);
    csr_valid = 1'b1;
    csr_we    = 1'b0;
    csr_addr  = a;
    #1;
    chk(tag, csr_rdata, exp);
    csr_valid = 1'b0;
  endtask

  task automatic clr_req();
    if_exc_valid = 1'b0;
    ex_exc_valid = 1'b0;
    ex_mret      = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    clr_req();
    if_exc_cause = '0; if_exc_pc = '0; if_exc_tval = '0;
    ex_exc_cause = '0; ex_exc_pc = '0; ex_exc_tval = '0;
    drained = 1'b1;
    redirect_ready = 1'b0;
    csr_valid = 1'b1; csr_addr = 12'h305; csr_we = 1'b0; csr_wdata = '0;
    if_exc_valid = 1'b1;
    #13;
    chk("rst_exc_ready", {31'b0, exc_ready}, 0);
    chk("rst_flush", {31'b0, flush}, 0);
    chk("rst_csr_ready", {31'b0, csr_ready}, 0);
    chk("rst_redir_valid", {31'b0, redirect_valid}, 0);
    clr_req();
    csr_valid = 1'b0;
    rst = 1'b1;
    tick();
    chk("idle_exc_ready", {31'b0, exc_ready}, 1);

    // mtvec write: old value in write cycle, new value after
    csr_valid = 1'b1; csr_we = 1'b1; csr_addr = 12'h305; csr_wdata = 32'h0E;
    #1;
    chk("wr_csr_ready", {31'b0, csr_ready}, 1);
    chk("wr_old_rdata", csr_rdata, 32'h0);
    tick();
    csr_we = 1'b0;
    #1;
    chk("wr_new_rdata", csr_rdata, 32'h0E);
    csr_valid = 1'b0;
    csr_rd("unmapped_rdata", 12'h7C0, 32'h0);
    chk("unmapped_hit", {31'b0, csr_hit}, 0);

    // ifetch trap, minimum latency
    if_exc_valid = 1'b1; if_exc_cause = 4'd2;
    if_exc_pc = 32'h4; if_exc_tval = 32'hFFF0A17F;
    #1;
    chk("t1_flush", {31'b0, flush}, 1);
    tick();
    clr_req();
    chk("t1_flush_pulse", {31'b0, flush}, 0);
    chk("t1_flush_busy", {31'b0, exc_ready}, 0);
    tick();
    chk("t1_commit_nv", {31'b0, redirect_valid}, 0);
    tick();
    chk("t1_redir_valid", {31'b0, redirect_valid}, 1);
    chk("t1_redir_pc", redirect_pc, 32'hC);
    redirect_ready = 1'b1;
    tick();
    redirect_ready = 1'b0;
    chk("t1_back_idle", {31'b0, redirect_valid}, 0);
    csr_rd("t1_mepc", 12'h341, 32'h4);
    csr_rd("t1_mcause", 12'h342, 32'h2);
    csr_rd("t1_mtval", 12'h343, 32'hFFF0A17F);

    // exec trap with MIE set; ifetch request in FLUSH ignored
    csr_wr(12'h305, 32'h1F);
    csr_wr(12'h300, 32'hFFFF_FF7F);
    csr_rd("t2_mstatus_mask", 12'h300, 32'h08);
    ex_exc_valid = 1'b1; ex_exc_cause = 4'd2;
    ex_exc_pc = 32'h14; ex_exc_tval = 32'hF11FD073;
    tick();
    clr_req();
    if_exc_valid = 1'b1; if_exc_cause = 4'd9; if_exc_pc = 32'h88;
    #1;
    chk("t2_flush_ign", {31'b0, flush}, 0);
    tick();
    tick();
    clr_req();
    chk("t2_redir_pc", redirect_pc, 32'h1C);
    redirect_ready = 1'b1;
    tick();
    redirect_ready = 1'b0;
    csr_rd("t2_mepc", 12'h341, 32'h14);
    csr_rd("t2_mcause", 12'h342, 32'h2);
    csr_rd("t2_mtval", 12'h343, 32'hF11FD073);
    csr_rd("t2_mstatus", 12'h300, 32'h80);
    csr_rd("t2_mtvec_mode", 12'h305, 32'h1F);

    // simultaneous ex + if, with CSR write in the same cycle
    ex_exc_valid = 1'b1; ex_exc_cause = 4'd4; ex_exc_pc = 32'h20;
    if_exc_valid = 1'b1; if_exc_cause = 4'd1; if_exc_pc = 32'h24;
    csr_valid = 1'b1; csr_we = 1'b1; csr_addr = 12'h305; csr_wdata = 32'h100;
    #1;
    chk("t3_csr_drop_rdy", {31'b0, csr_ready}, 0);
    tick();
    clr_req();
    csr_valid = 1'b0; csr_we = 1'b0;
    tick();
    tick();
    ex_exc_valid = 1'b1; ex_exc_pc = 32'h99;
    #1;
    chk("t3_redir_busy", {31'b0, exc_ready}, 0);
    chk("t3_redir_pc", redirect_pc, 32'h1C);
    redirect_ready = 1'b1;
    tick();
    clr_req();
    redirect_ready = 1'b0;
    csr_rd("t3_mepc", 12'h341, 32'h20);
    csr_rd("t3_mcause", 12'h342, 32'h4);
    csr_rd("t3_mtvec_kept", 12'h305, 32'h1F);

    // MRET: MIE <- MPIE, MPIE <- 1, target mepc
    csr_wr(12'h300, 32'h80);
    csr_wr(12'h341, 32'h3D);
    csr_rd("t4_mepc_align", 12'h341, 32'h3C);
    ex_mret = 1'b1;
    #1;
    chk("t4_mret_flush", {31'b0, flush}, 1);
    tick();
    clr_req();
    tick();
    tick();
    chk("t4_redir_pc", redirect_pc, 32'h3C);
    redirect_ready = 1'b1;
    tick();
    redirect_ready = 1'b0;
    csr_rd("t4_mstatus", 12'h300, 32'h88);

    // drained held low, redirect_ready held low
    drained = 1'b0;
    ex_exc_valid = 1'b1; ex_exc_cause = 4'd3;
    ex_exc_pc = 32'h40; ex_exc_tval = 32'h1;
    tick();
    clr_req();
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t5_stall_nv", {31'b0, redirect_valid}, 0);
    end
    csr_rd("t5_no_commit", 12'h342, 32'h4);
    drained = 1'b1;
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("t5_hold_valid", {31'b0, redirect_valid}, 1);
      chk("t5_hold_pc", redirect_pc, 32'h1C);
      tick();
    end
    redirect_ready = 1'b1;
    tick();
    redirect_ready = 1'b0;
    chk("t5_done", {31'b0, redirect_valid}, 0);
    csr_rd("t5_mcause", 12'h342, 32'h3);
    csr_rd("t5_mstatus", 12'h300, 32'h80);

    // reset during REDIRECT
    ex_exc_valid = 1'b1; ex_exc_cause = 4'd5; ex_exc_pc = 32'h50;
    tick();
    clr_req();
    tick();
    tick();
    chk("t6_pre_valid", {31'b0, redirect_valid}, 1);
    rst = 1'b0;
    #1;
    chk("t6_rst_valid", {31'b0, redirect_valid}, 0);
    chk("t6_rst_pc", redirect_pc, 32'h0);
    chk("t6_rst_ready", {31'b0, exc_ready}, 0);
    #10;
    rst = 1'b1;
    tick();
    chk("t6_rel_ready", {31'b0, exc_ready}, 1);
    chk("t6_rel_valid", {31'b0, redirect_valid}, 0);
    csr_rd("t6_mtvec", 12'h305, 32'h0);
    csr_rd("t6_mepc", 12'h341, 32'h0);
    csr_rd("t6_mcause", 12'h342, 32'h0);
    csr_rd("t6_mstatus", 12'h300, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
